// File: rtl/cook_timer_pkg.sv
// Shared definitions for the microwave cook timer.
//   state_e      : timer FSM states (IDLE = set/paused, RUN = counting, DONE = expired)
//   bcd_t        : one BCD digit
//   SEC_TENS_MAX : digit the seconds-tens position borrows to
//   BCD_MAX      : digit every other position borrows to
package cook_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef logic [3:0] bcd_t;

  localparam bcd_t SEC_TENS_MAX = 4'd5;
  localparam bcd_t BCD_MAX      = 4'd9;

endpackage

// File: rtl/cook_timer_bcd_down_digit.sv
// One position of the BCD countdown chain.
//   digit_i    : current digit value
//   dec_en_i   : decrement this digit (tick or borrow from the lower digit)
//   load_i     : keypad shift; takes priority over decrement
//   load_val_i : value shifted in on load
//   digit_o    : next digit value (combinational)
//   borrow_o   : this digit wrapped 0 -> MAX, the next digit must decrement
module bcd_down_digit
  import cook_timer_pkg::*;
#(
  parameter bcd_t MAX = BCD_MAX
) (
  input  bcd_t digit_i,
  input  logic dec_en_i,
  input  logic load_i,
  input  bcd_t load_val_i,
  output bcd_t digit_o,
  output logic borrow_o
);

  always_comb begin
    digit_o = digit_i;
    if (load_i) begin
      digit_o = load_val_i;
    end else if (dec_en_i) begin
      digit_o = (digit_i == 4'd0) ? MAX : digit_i - 4'd1;
    end
  end

  assign borrow_o = dec_en_i && !load_i && (digit_i == 4'd0);

endmodule

// File: rtl/cook_timer.sv
// Microwave cook timer: keypad-entered BCD mm:ss countdown, one step per second
// while the magnetron is on; timer_done tells the magnetron logic to drop its latch.
//   clk, reset           : clock, synchronous active-high reset
//   clearn               : active-low clear, zeroes the time in any state
//   mag_on               : magnetron latch state (1 = cooking)
//   key_valid, key_digit : keypad strobe and BCD digit
//   min_tens..sec_ones   : registered BCD display digits
//   timer_done           : level, time expired (held until clear/entry/reset)
//   running              : 1 while counting
module cook_timer
  import cook_timer_pkg::*;
#(
  parameter int CLK_FREQ = 50000000,
  parameter int PRE_W    = 26
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clearn,
  input  logic       mag_on,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       timer_done,
  output logic       running
);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_FREQ - 1);

  state_e           state_q;
  logic [PRE_W-1:0] pre_q;
  bcd_t             digit_q [4];   // [0]=sec_ones .. [3]=min_tens
  bcd_t             digit_d [4];
  logic [4:0]       dec_en;        // [gi] decrements digit gi, [4] = borrow past min_tens
  logic             timer_done_q;
  logic             running_q;

  logic key_accept;
  logic count_zero;
  logic next_zero;
  logic pre_wrap;
  logic tick;

  assign key_accept = key_valid && (key_digit <= BCD_MAX) && !mag_on;
  assign count_zero = (digit_q[0] == 4'd0) && (digit_q[1] == 4'd0) &&
                      (digit_q[2] == 4'd0) && (digit_q[3] == 4'd0);
  assign next_zero  = (digit_d[0] == 4'd0) && (digit_d[1] == 4'd0) &&
                      (digit_d[2] == 4'd0) && (digit_d[3] == 4'd0);
  assign pre_wrap   = (pre_q == PRE_LAST);
  // A zero count never produces a tick, so the chain cannot underflow.
  assign tick       = (state_q == ST_RUN) && pre_wrap && !count_zero;
  assign dec_en[0]  = tick;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
      localparam bcd_t DIG_MAX = (gi == 1) ? SEC_TENS_MAX : BCD_MAX;
      bcd_t load_val;
      if (gi == 0) begin : g_first
        assign load_val = key_digit;
      end else begin : g_rest
        assign load_val = digit_q[gi-1];
      end
      bcd_down_digit #(.MAX(DIG_MAX)) u_digit (
        .digit_i   (digit_q[gi]),
        .dec_en_i  (dec_en[gi]),
        .load_i    (key_accept),
        .load_val_i(load_val),
        .digit_o   (digit_d[gi]),
        .borrow_o  (dec_en[gi+1])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset || !clearn) begin
      state_q      <= ST_IDLE;
      pre_q        <= '0;
      timer_done_q <= 1'b0;
      running_q    <= 1'b0;
      for (int i = 0; i < 4; i++) digit_q[i] <= '0;
    end else if (key_accept) begin
      // Entry also leaves DONE (and a paused RUN) for IDLE; prescaler is held.
      for (int i = 0; i < 4; i++) digit_q[i] <= digit_d[i];
      state_q      <= ST_IDLE;
      timer_done_q <= 1'b0;
      running_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (mag_on) begin
            state_q   <= ST_RUN;
            running_q <= 1'b1;
          end
        end
        ST_RUN: begin
          if (count_zero) begin
            state_q      <= ST_DONE;
            timer_done_q <= 1'b1;
            running_q    <= 1'b0;
          end else begin
            // Prescaler advances even on the cycle mag_on drops, so a tick
            // coinciding with the pause still decrements.
            pre_q <= pre_wrap ? '0 : pre_q + PRE_W'(1);
            if (tick && !dec_en[4]) begin
              for (int i = 0; i < 4; i++) digit_q[i] <= digit_d[i];
            end
            if (tick && next_zero) begin
              state_q      <= ST_DONE;
              timer_done_q <= 1'b1;
              running_q    <= 1'b0;
            end else if (!mag_on) begin
              state_q   <= ST_IDLE;
              running_q <= 1'b0;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_DONE;
        end
        default: begin
          state_q   <= ST_IDLE;
          running_q <= 1'b0;
        end
      endcase
    end
  end

  assign sec_ones   = digit_q[0];
  assign sec_tens   = digit_q[1];
  assign min_ones   = digit_q[2];
  assign min_tens   = digit_q[3];
  assign timer_done = timer_done_q;
  assign running    = running_q;

endmodule

// File: tb/tb_cook_timer.sv
module tb_cook_timer;

  logic       clk = 1'b0;
  logic       reset;
  logic       clearn;
  logic       mag_on;
  logic       key_valid;
  logic [3:0] key_digit;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       timer_done;
  logic       running;

  int total_cnt = 0;
  int pass_cnt  = 0;

  cook_timer #(.CLK_FREQ(4), .PRE_W(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .clearn    (clearn),
    .mag_on    (mag_on),
    .key_valid (key_valid),
    .key_digit (key_digit),
    .min_tens  (min_tens),
    .min_ones  (min_ones),
    .sec_tens  (sec_tens),
    .sec_ones  (sec_ones),
    .timer_done(timer_done),
    .running   (running)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] disp();
    return {min_tens, min_ones, sec_tens, sec_ones};
  endfunction

  // Advance n rising edges and settle 1 time unit after the last one.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] d);
    key_valid = 1'b1;
    key_digit = d;
    cyc(1);
    key_valid = 1'b0;
    $display("key %0d -> display %h done=%0b run=%0b", d, disp(), timer_done, running);
  endtask

  task automatic clear_pulse();
    clearn = 1'b0;
    cyc(1);
    clearn = 1'b1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  initial begin
    int  n;
    bit  hit;
    logic [15:0] prev;

    reset = 1'b1; clearn = 1'b1; mag_on = 1'b0; key_valid = 1'b0; key_digit = 4'd0;

    // Reset held two cycles; clear and a key during reset do nothing.
    cyc(1);
    clearn = 1'b0; key_valid = 1'b1; key_digit = 4'd5;
    cyc(1);
    clearn = 1'b1; key_valid = 1'b0;
    check("reset_disp", disp(), 16'h0000);
    check("reset_done", {15'd0, timer_done}, 16'd0);
    check("reset_run",  {15'd0, running}, 16'd0);
    reset = 1'b0;

    // 01:30 countdown
    press(4'd1); press(4'd3); press(4'd0);
    check("entry_0130", disp(), 16'h0130);
    mag_on = 1'b1;
    cyc(1);
    check("run_start", {15'd0, running}, 16'd1);
    cyc(3);
    check("pre_tick_0130", disp(), 16'h0130);
    cyc(1);
    check("first_tick_0129", disp(), 16'h0129);
    n = 0; hit = 1'b0; prev = disp();
    while (!hit && n < 400) begin
      prev = disp();
      cyc(1);
      n++;
      if (disp() == 16'h0000) hit = 1'b1;
    end
    check("reach_zero", {15'd0, hit}, 16'd1);
    check("zero_cycles", n[15:0], 16'd356);
    check("prev_0001", prev, 16'h0001);
    check("done_on_edge", {15'd0, timer_done}, 16'd1);
    check("done_not_run", {15'd0, running}, 16'd0);
    cyc(3);
    check("done_hold", {disp()[14:0], timer_done}, 16'h0001);
    mag_on = 1'b0;
    clear_pulse();
    check("clear_done", {disp()[14:0], timer_done}, 16'h0000);

    // Non-normalised 00:90 and borrow chain 01:00 -> 00:59
    press(4'd0); press(4'd9); press(4'd0);
    mag_on = 1'b1;
    cyc(5);
    check("tick_0089", disp(), 16'h0089);
    mag_on = 1'b0;
    cyc(1);
    clear_pulse();
    press(4'd1); press(4'd0); press(4'd0);
    mag_on = 1'b1;
    cyc(5);
    check("borrow_0059", disp(), 16'h0059);
    mag_on = 1'b0;
    cyc(1);
    clear_pulse();

    // Pause/resume keeps prescaler phase
    press(4'd5);
    mag_on = 1'b1;
    cyc(3);
    mag_on = 1'b0;
    cyc(1);
    check("pause_idle", {15'd0, running}, 16'd0);
    cyc(10);
    check("pause_hold", disp(), 16'h0005);
    mag_on = 1'b1;
    cyc(1);
    check("resume_run", {disp()[14:0], running}, 16'h000B);
    cyc(1);
    check("resume_tick", disp(), 16'h0004);
    cyc(3);
    check("next_hold", disp(), 16'h0004);
    cyc(1);
    check("next_tick", disp(), 16'h0003);

    // Key during RUN ignored; clear mid-RUN
    press(4'd7);
    check("run_key_ign", {disp()[14:0], running}, 16'h0007);
    clearn = 1'b0;
    cyc(1);
    clearn = 1'b1;
    mag_on = 1'b0;
    check("clear_run_disp", disp(), 16'h0000);
    check("clear_run_flags", {14'd0, timer_done, running}, 16'd0);

    // Start with 00:00: DONE one cycle after RUN, no underflow
    mag_on = 1'b1;
    cyc(1);
    check("zero_run", {disp()[14:0], running}, 16'h0001);
    cyc(1);
    check("zero_done", {disp()[14:0], timer_done}, 16'h0001);
    cyc(3);
    check("zero_no_uflow", disp(), 16'h0000);
    mag_on = 1'b0;
    press(4'd5);
    check("done_entry", {disp()[13:0], timer_done, running}, 16'h0014);
    cyc(2);
    check("done_entry_idle", {15'd0, running}, 16'd0);

    // Invalid digit ignored, valid digit shifts
    press(4'd12);
    check("bad_digit", disp(), 16'h0005);
    press(4'd4);
    check("shift_0054", disp(), 16'h0054);

    // Maximum entry 99:99
    clear_pulse();
    press(4'd9); press(4'd9); press(4'd9); press(4'd9);
    mag_on = 1'b1;
    cyc(5);
    check("max_9998", disp(), 16'h9998);
    mag_on = 1'b0;
    cyc(1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
